// File: rtl/aclk_multi_alarm.sv
// rtl/aclk_multi_alarm.sv - BCD time of day with NUM_ALARMS ring/stop/snooze channels
// Optional: ACLK_RING_TIMEOUT_EN returns a ringing channel to ARMED after 60 unattended ticks.
module aclk_multi_alarm #(
  parameter int TICKS_PER_SEC = 10,
  parameter int NUM_ALARMS    = 4,
  parameter int SNOOZE_MIN    = 5,
  localparam int SELW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            H_in1,
  input  logic [3:0]            H_in0,
  input  logic [3:0]            M_in1,
  input  logic [3:0]            M_in0,
  input  logic                  LD_time,
  input  logic                  LD_alarm,
  input  logic [SELW-1:0]       alarm_sel,
  input  logic                  alarm_arm,
  input  logic                  stop_al,
  input  logic                  snooze,
  output logic [1:0]            H_out1,
  output logic [3:0]            H_out0,
  output logic [3:0]            M_out1,
  output logic [3:0]            M_out0,
  output logic [3:0]            S_out1,
  output logic [3:0]            S_out0,
  output logic [NUM_ALARMS-1:0] alarm,
  output logic                  alarm_any,
  output logic                  err
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [3:0] L_A0 = 4'(SNOOZE_MIN % 10);
  localparam logic [3:0] L_C0 = 4'(10 - (SNOOZE_MIN % 10));
  localparam logic [3:0] L_A1 = 4'(SNOOZE_MIN / 10);
  localparam logic [3:0] L_C1 = 4'(6 - (SNOOZE_MIN / 10));

  typedef enum logic [1:0] {S_DISARMED, S_ARMED, S_RINGING, S_SNOOZED} state_t;

  function automatic logic [5:0] hour_inc(input logic [1:0] h1, input logic [3:0] h0);
    if (h1 == 2'd2 && h0 == 4'd3) return 6'd0;
    else if (h0 == 4'd9)          return {h1 + 2'd1, 4'd0};
    else                          return {h1, h0 + 4'd1};
  endfunction

  function automatic logic bcd_ok(input logic [1:0] h1, input logic [3:0] h0,
                                  input logic [3:0] m1, input logic [3:0] m0);
    return (h0 <= 4'd9) && (m1 <= 4'd5) && (m0 <= 4'd9) &&
           ((h1 < 2'd2) || (h1 == 2'd2 && h0 <= 4'd3));
  endfunction

  logic [PW-1:0] r_presc;
  logic [1:0]    r_h1;
  logic [3:0]    r_h0, r_m1, r_m0, r_s1, r_s0;
  logic          r_upd, r_err;
  state_t        r_state [NUM_ALARMS];
  state_t        w_next  [NUM_ALARMS];
  logic [1:0]    r_al_h1 [NUM_ALARMS];
  logic [3:0]    r_al_h0 [NUM_ALARMS];
  logic [3:0]    r_al_m1 [NUM_ALARMS];
  logic [3:0]    r_al_m0 [NUM_ALARMS];
  logic [1:0]    r_sz_h1 [NUM_ALARMS];
  logic [3:0]    r_sz_h0 [NUM_ALARMS];
  logic [3:0]    r_sz_m1 [NUM_ALARMS];
  logic [3:0]    r_sz_m0 [NUM_ALARMS];
`ifdef ACLK_RING_TIMEOUT_EN
  logic [5:0]    r_tmo   [NUM_ALARMS];
`endif

  logic       w_tick, w_time_ok, w_al_ok, w_ld_time, w_ld_al, w_on_min;
  logic       w_c0, w_c1;
  logic [3:0] w_m1c, w_snz_m0, w_snz_m1, w_snz_h0;
  logic [1:0] w_snz_h1;

  assign w_tick    = (r_presc == PW'(TICKS_PER_SEC - 1));
  assign w_time_ok = bcd_ok(H_in1, H_in0, M_in1, M_in0);
  assign w_al_ok   = w_time_ok && (int'(alarm_sel) < NUM_ALARMS);
  assign w_ld_time = LD_time && w_time_ok;
  assign w_ld_al   = LD_alarm && w_al_ok;
  assign w_on_min  = r_upd && (r_s1 == 4'd0) && (r_s0 == 4'd0);

  // Snooze target: BCD minute add with carry into hours, thresholds folded into constants.
  assign w_c0     = (r_m0 >= L_C0);
  assign w_snz_m0 = w_c0 ? r_m0 - L_C0 : r_m0 + L_A0;
  assign w_m1c    = r_m1 + {3'd0, w_c0};
  assign w_c1     = (w_m1c >= L_C1);
  assign w_snz_m1 = w_c1 ? w_m1c - L_C1 : w_m1c + L_A1;
  assign {w_snz_h1, w_snz_h0} = w_c1 ? hour_inc(r_h1, r_h0) : {r_h1, r_h0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_h1 <= '0; r_h0 <= '0; r_m1 <= '0; r_m0 <= '0; r_s1 <= '0; r_s0 <= '0;
      r_upd <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_upd <= w_ld_time | w_tick;
      r_err <= (LD_time & ~w_time_ok) | (LD_alarm & ~w_al_ok);
      if (w_ld_time) begin
        r_presc <= '0;
        r_h1 <= H_in1; r_h0 <= H_in0; r_m1 <= M_in1; r_m0 <= M_in0;
        r_s1 <= '0;    r_s0 <= '0;
      end else begin
        r_presc <= w_tick ? '0 : r_presc + PW'(1);
        if (w_tick) begin
          if (r_s0 != 4'd9) r_s0 <= r_s0 + 4'd1;
          else begin
            r_s0 <= '0;
            if (r_s1 != 4'd5) r_s1 <= r_s1 + 4'd1;
            else begin
              r_s1 <= '0;
              if (r_m0 != 4'd9) r_m0 <= r_m0 + 4'd1;
              else begin
                r_m0 <= '0;
                if (r_m1 != 4'd5) r_m1 <= r_m1 + 4'd1;
                else begin
                  r_m1 <= '0;
                  {r_h1, r_h0} <= hour_inc(r_h1, r_h0);
                end
              end
            end
          end
        end
      end
    end
  end

  // stop_al also suppresses a same-cycle match so a stopped channel stays quiet.
  always_comb begin
    for (int i = 0; i < NUM_ALARMS; i++) begin
      w_next[i] = r_state[i];
      if (w_ld_al && int'(alarm_sel) == i) begin
        w_next[i] = alarm_arm ? S_ARMED : S_DISARMED;
      end else begin
        case (r_state[i])
          S_ARMED:
            if (!stop_al && w_on_min && r_h1 == r_al_h1[i] && r_h0 == r_al_h0[i] &&
                r_m1 == r_al_m1[i] && r_m0 == r_al_m0[i])
              w_next[i] = S_RINGING;
          S_RINGING:
            if (stop_al)     w_next[i] = S_ARMED;
            else if (snooze) w_next[i] = S_SNOOZED;
`ifdef ACLK_RING_TIMEOUT_EN
            else if (w_tick && r_tmo[i] == 6'd59) w_next[i] = S_ARMED;
`endif
          S_SNOOZED:
            if (stop_al) w_next[i] = S_ARMED;
            else if (w_on_min && r_h1 == r_sz_h1[i] && r_h0 == r_sz_h0[i] &&
                     r_m1 == r_sz_m1[i] && r_m0 == r_sz_m0[i])
              w_next[i] = S_RINGING;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        r_state[i] <= S_DISARMED;
        r_al_h1[i] <= '0; r_al_h0[i] <= '0; r_al_m1[i] <= '0; r_al_m0[i] <= '0;
        r_sz_h1[i] <= '0; r_sz_h0[i] <= '0; r_sz_m1[i] <= '0; r_sz_m0[i] <= '0;
`ifdef ACLK_RING_TIMEOUT_EN
        r_tmo[i]   <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        r_state[i] <= w_next[i];
        if (w_ld_al && int'(alarm_sel) == i) begin
          r_al_h1[i] <= H_in1; r_al_h0[i] <= H_in0; r_al_m1[i] <= M_in1; r_al_m0[i] <= M_in0;
        end
        if (r_state[i] == S_RINGING && w_next[i] == S_SNOOZED) begin
          r_sz_h1[i] <= w_snz_h1; r_sz_h0[i] <= w_snz_h0;
          r_sz_m1[i] <= w_snz_m1; r_sz_m0[i] <= w_snz_m0;
        end
`ifdef ACLK_RING_TIMEOUT_EN
        if (w_next[i] == S_RINGING && r_state[i] != S_RINGING) r_tmo[i] <= '0;
        else if (r_state[i] == S_RINGING && w_tick)            r_tmo[i] <= r_tmo[i] + 6'd1;
`endif
      end
    end
  end

  always_comb begin
    alarm = '0;
    for (int i = 0; i < NUM_ALARMS; i++) alarm[i] = (r_state[i] == S_RINGING);
  end

  assign alarm_any = |alarm;
  assign err       = r_err;
  assign H_out1 = r_h1;
  assign H_out0 = r_h0;
  assign M_out1 = r_m1;
  assign M_out0 = r_m0;
  assign S_out1 = r_s1;
  assign S_out0 = r_s0;

endmodule

// File: tb/tb_aclk_multi_alarm.sv
// tb/tb_aclk_multi_alarm.sv - scoreboard bench for aclk_multi_alarm against a seconds-of-day model
module tb_aclk_multi_alarm;
  localparam int TPS = 10;
  localparam int NA  = 4;
  localparam int SN  = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] H_in1 = '0;
  logic [3:0] H_in0 = '0, M_in1 = '0, M_in0 = '0;
  logic       LD_time = 1'b0, LD_alarm = 1'b0, alarm_arm = 1'b0, stop_al = 1'b0, snooze = 1'b0;
  logic [1:0] alarm_sel = '0;
  logic [1:0] H_out1;
  logic [3:0] H_out0, M_out1, M_out0, S_out1, S_out0;
  logic [NA-1:0] alarm;
  logic       alarm_any, err;

  aclk_multi_alarm #(.TICKS_PER_SEC(TPS), .NUM_ALARMS(NA), .SNOOZE_MIN(SN)) dut (
    .clk(clk), .reset(reset),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .alarm_sel(alarm_sel), .alarm_arm(alarm_arm),
    .stop_al(stop_al), .snooze(snooze),
    .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
    .S_out1(S_out1), .S_out0(S_out0),
    .alarm(alarm), .alarm_any(alarm_any), .err(err)
  );

  always #5 clk = ~clk;

  // Model: time as seconds of day, alarms and snooze targets as minutes of day.
  localparam int DIS = 0, ARM = 1, RING = 2, SNZ = 3;
  int m_tsec, m_pc, m_upd, m_err;
  int m_st [NA];
  int m_al [NA];
  int m_sz [NA];
  int m_rt [NA];
  logic [27:0] exp_q [$];
  int vectors = 0;
  int miscompares = 0;

  function automatic bit valid_hm(int h1, int h0, int m1, int m0);
    return (h0 <= 9) && (m1 <= 5) && (m0 <= 9) && (h1 * 10 + h0 <= 23);
  endfunction

  function automatic logic [27:0] pack_exp();
    int h, m, s;
    logic [NA-1:0] al;
    h = m_tsec / 3600; m = (m_tsec / 60) % 60; s = m_tsec % 60;
    for (int i = 0; i < NA; i++) al[i] = (m_st[i] == RING);
    return {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
            al, |al, 1'(m_err)};
  endfunction

  task automatic model_reset();
    m_tsec = 0; m_pc = 0; m_upd = 0; m_err = 0;
    for (int i = 0; i < NA; i++) begin m_st[i] = DIS; m_al[i] = 0; m_sz[i] = 0; m_rt[i] = 0; end
  endtask

  task automatic model_step();
    bit tick, tok, aok, on_min;
    int ld_min, cur_min, snz, sel;
    tick    = (m_pc == TPS - 1);
    tok     = valid_hm(int'(H_in1), int'(H_in0), int'(M_in1), int'(M_in0));
    sel     = int'(alarm_sel);
    aok     = tok && (sel < NA);
    ld_min  = (int'(H_in1) * 10 + int'(H_in0)) * 60 + int'(M_in1) * 10 + int'(M_in0);
    cur_min = m_tsec / 60;
    on_min  = (m_upd != 0) && (m_tsec % 60 == 0);
    snz     = (cur_min + SN) % 1440;
    for (int i = 0; i < NA; i++) begin
      if (LD_alarm && aok && sel == i) begin
        m_al[i] = ld_min;
        m_st[i] = alarm_arm ? ARM : DIS;
      end else if (stop_al && m_st[i] != DIS) begin
        m_st[i] = ARM;
      end else if (snooze && m_st[i] == RING) begin
        m_st[i] = SNZ; m_sz[i] = snz;
      end else if ((m_st[i] == ARM && on_min && cur_min == m_al[i]) ||
                   (m_st[i] == SNZ && on_min && cur_min == m_sz[i])) begin
        m_st[i] = RING; m_rt[i] = 0;
      end else if (m_st[i] == RING && tick) begin
`ifdef ACLK_RING_TIMEOUT_EN
        if (m_rt[i] == 59) m_st[i] = ARM;
`endif
        m_rt[i]++;
      end
    end
    if (LD_time && tok) begin
      m_tsec = ld_min * 60; m_pc = 0;
    end else begin
      m_pc = tick ? 0 : m_pc + 1;
      if (tick) m_tsec = (m_tsec + 1) % 86400;
    end
    m_upd = (LD_time && tok) || tick;
    m_err = (LD_time && !tok) || (LD_alarm && !aok);
  endtask

  task automatic cycle();
    @(posedge clk); #1;
    model_step();
    exp_q.push_back(pack_exp());
    LD_time = 0; LD_alarm = 0; stop_al = 0; snooze = 0;
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    model_reset();
    exp_q.push_back(pack_exp());
    repeat (n) begin @(posedge clk); #1; exp_q.push_back(pack_exp()); end
    reset = 1'b0;
  endtask

  task automatic set_hm(int hh, int mm);
    H_in1 = 2'(hh / 10); H_in0 = 4'(hh % 10); M_in1 = 4'(mm / 10); M_in0 = 4'(mm % 10);
  endtask

  task automatic ld_time_t(int hh, int mm);
    set_hm(hh, mm); LD_time = 1; cycle();
  endtask

  task automatic ld_al(int ch, int hh, int mm, bit arm);
    set_hm(hh, mm); LD_alarm = 1; alarm_sel = 2'(ch); alarm_arm = arm; cycle();
  endtask

  initial begin : monitor
    logic [27:0] e, a;
    @(posedge clk);
    forever begin
      @(negedge clk);
      a = {H_out1, H_out0, M_out1, M_out0, S_out1, S_out0, alarm, alarm_any, err};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_empty at %0t got=%h", $time, a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          miscompares++;
          if (miscompares <= 40)
            $display("FAIL outputs at %0t got=%h required=%h (hhmmss,alarm,any,err)", $time, a, e);
        end
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int tgt, ch;
    bit do_t, do_a;
    @(posedge clk); #1;
    do_reset(2);
    run(25);
    // wrap past midnight
    ld_time_t(23, 59);
    run(TPS * 60 + 5);
    // rejected loads
    ld_time_t(24, 0);
    run(3);
    ld_al(0, 7, 60, 1);
    run(3);
    // multi-channel ring
    ld_al(0, 7, 30, 1);
    ld_al(2, 7, 30, 1);
    ld_al(1, 7, 30, 0);
    ld_time_t(7, 29);
    run(TPS * 60 + 10);
    stop_al = 1; cycle();
    run(20);
    // snooze across midnight
    ld_al(3, 23, 58, 1);
    ld_time_t(23, 57);
    run(TPS * 60 + 10);
    snooze = 1; cycle();
    run(TPS * 60 * SN + 10);
    stop_al = 1; cycle();
    run(TPS * 20);
    // simultaneous loads, long ring, reset mid-ring
    set_hm(6, 0); LD_time = 1; LD_alarm = 1; alarm_sel = 2'd1; alarm_arm = 1; cycle();
    run(TPS * 125);
    do_reset(3);
    run(TPS * 3);
    // randomized traffic
    for (int n = 0; n < 20000; n++) begin
      do_t = ($urandom_range(0, 199) == 0);
      do_a = ($urandom_range(0, 49) == 0);
      if (do_t || do_a) begin
        if ($urandom_range(0, 4) == 0) begin
          H_in1 = 2'($urandom); H_in0 = 4'($urandom); M_in1 = 4'($urandom); M_in0 = 4'($urandom);
        end else if (do_t) begin
          ch  = $urandom_range(0, NA - 1);
          tgt = (m_al[ch] - $urandom_range(0, 1) + 1440) % 1440;
          set_hm(tgt / 60, tgt % 60);
        end else begin
          tgt = (m_tsec / 60 + $urandom_range(0, 2)) % 1440;
          set_hm(tgt / 60, tgt % 60);
        end
        LD_time = do_t; LD_alarm = do_a;
        alarm_sel = 2'($urandom_range(0, NA - 1));
        alarm_arm = ($urandom_range(0, 3) != 0);
      end
      stop_al = ($urandom_range(0, 299) == 0);
      snooze  = ($urandom_range(0, 149) == 0);
      cycle();
      if (n == 10000) do_reset(2);
    end
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
